// File: rtl/recorrido_der_izq_ctrl.sv
// Bit-serial LSB->MSB unsigned comparator controller: scans one bit pair per clock.
// Result presented in DONE with valid/ack; the last differing bit scanned decides the ordering.
module recorrido_der_izq_ctrl #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  wordA,
  input  logic [N-1:0]  wordB,
  input  logic          ack,
  output logic          busy,
  output logic          valid,
  output logic          a_bit,
  output logic          b_bit,
  output logic [CW-1:0] bit_idx,
  output logic          gt,
  output logic          eq,
  output logic          lt
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sha_q, sha_d;
  logic [N-1:0]  shb_q, shb_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = wordA;
          shb_d   = wordB;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Later (more significant) differing bits overwrite earlier verdicts.
        if (sha_q[0] != shb_q[0]) begin
          gt_d = sha_q[0];
          lt_d = shb_q[0];
        end
        if (idx_q == CW'(N - 1)) begin
          sha_d   = '0;
          shb_d   = '0;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          sha_d = sha_q >> 1;
          shb_d = shb_q >> 1;
          idx_d = idx_q + CW'(1);
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == SCAN);
  assign valid   = (state_q == DONE);
  assign a_bit   = sha_q[0];
  assign b_bit   = shb_q[0];
  assign bit_idx = idx_q;
  assign gt      = valid & gt_q;
  assign lt      = valid & lt_q;
  assign eq      = valid & ~gt_q & ~lt_q;

endmodule
